// File: rtl/bin_reorder_buffer_pkg.sv
// Shared constants and state encodings for the bin reorder buffer.
package bin_reorder_buffer_pkg;

  localparam int DATA_W = 128;
  localparam int IDX_W  = 6;
  localparam int NBINS  = 2 ** IDX_W;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  typedef enum logic {
    WR_ACCEPT,
    WR_DROP
  } wr_state_t;

endpackage

// File: rtl/bin_reorder_buffer_bin_bank.sv
// One frame bank: bin memory, written-bitmap, random-index write port and a
// read port that substitutes zero for bins not written in this frame.
module bin_bank
  import bin_reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NBINS];
  logic [NBINS-1:0]  written;

  // Memory write; contents are never cleared, the bitmap decides validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Written-bitmap: set on each write, wiped when the frame finishes draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       written <= '0;
    else if (clr)   written <= '0;
    else if (wr_en) written[wr_addr] <= 1'b1;
  end

  // Zero-substituting read; the top registers this value into its output stage.
  always_comb begin
    rd_data = written[rd_addr] ? mem[rd_addr] : '0;
  end

endmodule

// File: rtl/bin_reorder_buffer.sv
// Ping-pong reorder buffer: captures bins in arbitrary order, replays each
// completed frame in natural bin order with valid/ready output.
module bin_reorder_buffer
  import bin_reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              raise_valid,
  input  logic              raise_fin,
  input  logic [DATA_W-1:0] raise_data,
  input  logic [IDX_W-1:0]  freq_out,
  input  logic              ifft_ready,
  output logic              ifft_valid,
  output logic [DATA_W-1:0] ifft_data,
  output logic [IDX_W-1:0]  ifft_idx,
  output logic              ifft_fin,
  output logic              overflow
);

  bank_state_t       bank_st [2];
  wr_state_t         wr_st;
  logic              wb;
  logic              rb;
  logic [DATA_W-1:0] bank_rd_data [2];

  logic              wb_open;
  logic              write_beat;
  logic              xfer;
  logic              fin_xfer;
  logic              load_en;
  logic              load_bank;
  logic [IDX_W-1:0]  load_idx;

  // Decode this cycle's write acceptance and which bin (if any) the output stage loads.
  always_comb begin
    wb_open    = (bank_st[wb] == BANK_EMPTY) || (bank_st[wb] == BANK_FILLING);
    write_beat = (wr_st == WR_ACCEPT) && raise_valid && wb_open;
    xfer       = ifft_valid && ifft_ready;
    fin_xfer   = xfer && ifft_fin;
    load_en    = 1'b0;
    load_bank  = rb;
    load_idx   = '0;
    if (!ifft_valid) begin
      load_en = (bank_st[rb] == BANK_FULL);
    end else if (xfer) begin
      if (!ifft_fin) begin
        load_en  = 1'b1;
        load_idx = ifft_idx + 1'b1;
      end else if (bank_st[!rb] == BANK_FULL) begin
        // Next frame already waiting: start it on the same edge, no bubble.
        load_en   = 1'b1;
        load_bank = !rb;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      bin_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (write_beat && (wb == 1'(gi))),
        .wr_addr (freq_out),
        .wr_data (raise_data),
        .clr     (fin_xfer && (rb == 1'(gi))),
        .rd_addr (load_idx),
        .rd_data (bank_rd_data[gi])
      );
    end
  endgenerate

  // Bank lifecycle, bank pointers, writer state and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
      wr_st      <= WR_ACCEPT;
      wb         <= 1'b0;
      rb         <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // Reader side only touches FULL/DRAINING banks, writer only EMPTY/FILLING,
      // so the two never update the same bank on one edge.
      if (load_en && (load_idx == '0)) bank_st[load_bank] <= BANK_DRAINING;
      if (fin_xfer) begin
        bank_st[rb] <= BANK_EMPTY;
        rb          <= !rb;
      end
      case (wr_st)
        WR_ACCEPT: begin
          if (raise_valid && !wb_open) begin
            overflow <= 1'b1;
            // A dropped beat that also ends its frame leaves nothing to skip.
            if (!raise_fin) wr_st <= WR_DROP;
          end
          if (write_beat) begin
            bank_st[wb] <= raise_fin ? BANK_FULL : BANK_FILLING;
          end else if (raise_fin && (bank_st[wb] == BANK_FILLING)) begin
            bank_st[wb] <= BANK_FULL;
          end
          if (raise_fin && (write_beat || (bank_st[wb] == BANK_FILLING))) wb <= !wb;
        end
        WR_DROP: begin
          if (raise_fin) wr_st <= WR_ACCEPT;
        end
        default: wr_st <= WR_ACCEPT;
      endcase
    end
  end

  // Output register: holds under stall, advances one bin per transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifft_valid <= 1'b0;
      ifft_data  <= '0;
      ifft_idx   <= '0;
      ifft_fin   <= 1'b0;
    end else if (load_en) begin
      ifft_valid <= 1'b1;
      ifft_data  <= bank_rd_data[load_bank];
      ifft_idx   <= load_idx;
      ifft_fin   <= &load_idx;
    end else if (fin_xfer) begin
      ifft_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bin_reorder_buffer.sv
// Self-checking bench for bin_reorder_buffer: directed vector tables plus
// randomized traffic checked against a frame-level reference model.
module tb_bin_reorder_buffer;
  import bin_reorder_buffer_pkg::*;

  localparam int DW = DATA_W;
  localparam int IW = IDX_W;
  localparam int NB = NBINS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          raise_valid;
  logic          raise_fin;
  logic [DW-1:0] raise_data;
  logic [IW-1:0] freq_out;
  logic          ifft_ready;
  logic          ifft_valid;
  logic [DW-1:0] ifft_data;
  logic [IW-1:0] ifft_idx;
  logic          ifft_fin;
  logic          overflow;

  always #5 clk = ~clk;

  bin_reorder_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .raise_valid (raise_valid),
    .raise_fin   (raise_fin),
    .raise_data  (raise_data),
    .freq_out    (freq_out),
    .ifft_ready  (ifft_ready),
    .ifft_valid  (ifft_valid),
    .ifft_data   (ifft_data),
    .ifft_idx    (ifft_idx),
    .ifft_fin    (ifft_fin),
    .overflow    (overflow)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          fin;
  } beat_t;

  typedef struct {
    logic          v;
    logic          fin;
    logic [IW-1:0] idx;
    logic [DW-1:0] din;
    logic [IW-1:0] chk_idx;
    logic [DW-1:0] chk_data;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frames as whole units, output stream as a queue.
  beat_t         exp_q[$];
  logic [DW-1:0] m_data [NB];
  bit            m_wr   [NB];
  bit            m_filling;
  bit            m_drop;
  bit            m_ovf;
  int            m_held;

  bit            p_stall;
  logic [DW-1:0] p_data;
  logic [IW-1:0] p_idx;
  logic          p_fin;

  int            cyc;
  int            first_valid_cyc;
  int            xfer_cnt;
  logic [DW-1:0] got_data [NB];

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int b = 0; b < NB; b++) m_wr[b] = 1'b0;
    m_filling = 1'b0;
    m_drop    = 1'b0;
    m_ovf     = 1'b0;
    m_held    = 0;
    p_stall   = 1'b0;
  endtask

  task automatic clear_got();
    for (int b = 0; b < NB; b++) got_data[b] = '1;
  endtask

  // One clock cycle: drive inputs, check outputs of this cycle, advance model.
  task automatic step(input logic v, input logic fin, input logic [IW-1:0] idx,
                      input logic [DW-1:0] d, input logic rdy);
    beat_t e;
    bit    fin_xfer;
    raise_valid = v;
    raise_fin   = fin;
    freq_out    = idx;
    raise_data  = d;
    ifft_ready  = rdy;
    chk("overflow", overflow, m_ovf);
    if (p_stall) begin
      chk("stall_valid", ifft_valid, 1'b1);
      chk("stall_data", ifft_data, p_data);
      chk("stall_idx", ifft_idx, p_idx);
      chk("stall_fin", ifft_fin, p_fin);
    end
    if (ifft_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    fin_xfer = 1'b0;
    if (ifft_valid && rdy) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got idx %0d data %0h, no beat expected", ifft_idx, ifft_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_idx", ifft_idx, e.idx);
        chk("beat_data", ifft_data, e.data);
        chk("beat_fin", ifft_fin, e.fin);
      end
      got_data[ifft_idx] = ifft_data;
      fin_xfer = ifft_fin;
    end
    p_stall = ifft_valid && !rdy;
    p_data  = ifft_data;
    p_idx   = ifft_idx;
    p_fin   = ifft_fin;
    // Writer rules: two frames already held means there is no room for a third.
    if (!m_drop) begin
      if (v) begin
        if (m_held < 2) begin
          m_data[idx] = d;
          m_wr[idx]   = 1'b1;
          m_filling   = 1'b1;
        end else begin
          m_ovf = 1'b1;
          if (!fin) m_drop = 1'b1;
        end
      end
      if (fin && m_filling) begin
        for (int b = 0; b < NB; b++) begin
          e.idx  = IW'(b);
          e.data = m_wr[b] ? m_data[b] : '0;
          e.fin  = (b == NB - 1);
          exp_q.push_back(e);
          m_wr[b] = 1'b0;
        end
        m_held++;
        m_filling = 1'b0;
      end
    end else if (fin) begin
      m_drop = 1'b0;
    end
    if (fin_xfer) m_held--;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int bound, input bit toggle);
    int k = 0;
    while ((exp_q.size() != 0 || ifft_valid) && k < bound) begin
      step(1'b0, 1'b0, '0, '0, toggle ? cyc[0] : 1'b1);
      k++;
    end
    chk("drain_done", (exp_q.size() == 0 && !ifft_valid), 1'b1);
  endtask

  vec_t vecs [8];
  int   fin_cyc;
  bit   found;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 6'd5,  128'hAA, 6'd5,  128'hAA};
    vecs[1] = '{1'b1, 1'b0, 6'd40, 128'hBB, 6'd40, 128'hBB};
    vecs[2] = '{1'b0, 1'b1, 6'd0,  128'h0,  6'd0,  128'h0};
    vecs[3] = '{1'b0, 1'b0, 6'd0,  128'h0,  6'd39, 128'h0};
    vecs[4] = '{1'b0, 1'b0, 6'd0,  128'h0,  6'd63, 128'h0};
    vecs[5] = '{1'b1, 1'b0, 6'd7,  128'h1,  6'd7,  128'h2};
    vecs[6] = '{1'b1, 1'b0, 6'd7,  128'h2,  6'd6,  128'h0};
    vecs[7] = '{1'b0, 1'b1, 6'd0,  128'h0,  6'd8,  128'h0};

    raise_valid = 1'b0;
    raise_fin   = 1'b0;
    raise_data  = '0;
    freq_out    = '0;
    ifft_ready  = 1'b0;
    cyc         = 0;
    xfer_cnt    = 0;
    first_valid_cyc = -1;
    model_reset();
    clear_got();
    repeat (2) @(negedge clk);
    chk("rst_valid", ifft_valid, 1'b0);
    chk("rst_data", ifft_data, '0);
    chk("rst_idx", ifft_idx, '0);
    chk("rst_fin", ifft_fin, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b1;

    // Full frame written in reverse bin order, fin on the last beat.
    first_valid_cyc = -1;
    xfer_cnt = 0;
    fin_cyc = 0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (b == 0) fin_cyc = cyc;
      step(1'b1, (b == 0), IW'(b), DW'(256 + b), 1'b1);
    end
    drain(200, 1'b0);
    chk("t1_latency", DW'(first_valid_cyc - fin_cyc), DW'(2));
    chk("t1_beats", DW'(xfer_cnt), DW'(NB));

    // Sparse frame from the vector table.
    clear_got();
    for (int i = 0; i < 5; i++) step(vecs[i].v, vecs[i].fin, vecs[i].idx, vecs[i].din, 1'b1);
    drain(200, 1'b0);
    for (int i = 0; i < 5; i++) chk("t2_sparse_bin", got_data[vecs[i].chk_idx], vecs[i].chk_data);

    // Two back-to-back random frames with ready toggling every cycle.
    xfer_cnt = 0;
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < NB; b++)
        step(1'b1, (b == NB - 1), IW'($urandom_range(0, NB - 1)),
             {$urandom(), $urandom(), $urandom(), $urandom()}, cyc[0]);
    drain(400, 1'b1);
    chk("t3_beats", DW'(xfer_cnt), DW'(2 * NB));
    chk("t3_overflow", overflow, 1'b0);

    // Ready held low while three frames arrive: the third is dropped.
    xfer_cnt = 0;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 8; b++)
        step(1'b1, (b == 7), IW'(b * 3 + f), DW'(f * 16 + b + 1), 1'b0);
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b0);
    chk("t4_overflow", overflow, 1'b1);
    chk("t4_held_beats", DW'(xfer_cnt), DW'(0));
    drain(400, 1'b0);
    chk("t4_beats", DW'(xfer_cnt), DW'(2 * NB));

    // Duplicate index from the table, then a fin with no beats.
    clear_got();
    for (int i = 5; i < 8; i++) step(vecs[i].v, vecs[i].fin, vecs[i].idx, vecs[i].din, 1'b1);
    drain(200, 1'b0);
    for (int i = 5; i < 8; i++) chk("t5_dup_bin", got_data[vecs[i].chk_idx], vecs[i].chk_data);
    xfer_cnt = 0;
    step(1'b0, 1'b1, '0, '0, 1'b1);
    repeat (6) step(1'b0, 1'b0, '0, '0, 1'b1);
    chk("t5_empty_fin_valid", ifft_valid, 1'b0);
    chk("t5_empty_fin_beats", DW'(xfer_cnt), DW'(0));

    // Reset mid-drain at idx 20, then a fresh frame.
    for (int b = 0; b < NB; b++) step(1'b1, (b == NB - 1), IW'(NB - 1 - b), DW'(b + 1), 1'b1);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (ifft_valid && ifft_idx == IW'(20)) found = 1'b1;
      else step(1'b0, 1'b0, '0, '0, 1'b1);
    end
    chk("t6_reach_idx20", found, 1'b1);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", ifft_valid, 1'b0);
    chk("t6_rst_data", ifft_data, '0);
    chk("t6_rst_idx", ifft_idx, '0);
    chk("t6_rst_fin", ifft_fin, 1'b0);
    chk("t6_rst_overflow", overflow, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    first_valid_cyc = -1;
    xfer_cnt = 0;
    for (int b = 0; b < NB; b += 2) begin
      if (b == NB - 2) fin_cyc = cyc;
      step(1'b1, (b == NB - 2), IW'(b), DW'(b + 16'h500), 1'b1);
    end
    drain(200, 1'b0);
    chk("t6_latency", DW'(first_valid_cyc - fin_cyc), DW'(2));
    chk("t6_beats", DW'(xfer_cnt), DW'(NB));

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
           IW'($urandom_range(0, NB - 1)),
           {$urandom(), $urandom(), $urandom(), $urandom()},
           ($urandom_range(0, 2) != 0));
    step(1'b0, 1'b1, '0, '0, 1'b1);
    drain(400, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
